// File: rtl/dcache_wt.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
// A single outstanding core request is serviced at a time against a simple valid/ack memory port.
module dcache_wt #(
    parameter int NUM_LINES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_rreq,
    input  logic        dcache_wreq,
    input  logic [31:0] dcache_wdata,
    input  logic [3:0]  dcache_byte_enable,
    output logic [31:0] dcache_rdata,
    output logic        dcache_rvalid,
    output logic        dcache_wvalid,
    output logic [31:0] mem_addr,
    output logic        mem_rreq,
    output logic        mem_wreq,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic        mem_wvalid
);

    // state     | meaning
    // IDLE      | waiting for a core request
    // READ_MISS | refill read outstanding on the memory port
    // WRITE_MEM | write-through outstanding on the memory port
    // RESP      | one-cycle response pulse to the core
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 30 - IW;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] READ_MISS = 2'd1;
    localparam logic [1:0] WRITE_MEM = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    logic [1:0]           state;
    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    logic [IW-1:0] req_index;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] fill_index;
    logic [TW-1:0] fill_tag;
    logic          hit;

    assign req_index  = dcache_addr[2+IW-1:2];
    assign req_tag    = dcache_addr[31:2+IW];
    // Refill targets the registered miss address, not the live core bus.
    assign fill_index = mem_addr[2+IW-1:2];
    assign fill_tag   = mem_addr[31:2+IW];
    assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);

    // Tag/data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == IDLE && dcache_wreq && hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (dcache_byte_enable[b]) begin
                        data_q[req_index][8*b +: 8] <= dcache_wdata[8*b +: 8];
                    end
                end
            end
            if (state == READ_MISS && mem_rvalid) begin
                tag_q[fill_index]  <= fill_tag;
                data_q[fill_index] <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            valid_q         <= '0;
            dcache_rdata    <= '0;
            dcache_rvalid   <= 1'b0;
            dcache_wvalid   <= 1'b0;
            mem_addr        <= '0;
            mem_rreq        <= 1'b0;
            mem_wreq        <= 1'b0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dcache_wreq) begin
                        mem_wreq        <= 1'b1;
                        mem_addr        <= dcache_addr & 32'hFFFF_FFFC;
                        mem_wdata       <= dcache_wdata;
                        mem_byte_enable <= dcache_byte_enable;
                        state           <= WRITE_MEM;
                    end else if (dcache_rreq) begin
                        if (hit) begin
                            dcache_rdata  <= data_q[req_index];
                            dcache_rvalid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            mem_rreq <= 1'b1;
                            mem_addr <= dcache_addr & 32'hFFFF_FFFC;
                            state    <= READ_MISS;
                        end
                    end
                end
                READ_MISS: begin
                    if (mem_rvalid) begin
                        mem_rreq            <= 1'b0;
                        valid_q[fill_index] <= 1'b1;
                        dcache_rdata        <= mem_rdata;
                        dcache_rvalid       <= 1'b1;
                        state               <= RESP;
                    end
                end
                WRITE_MEM: begin
                    if (mem_wvalid) begin
                        mem_wreq      <= 1'b0;
                        dcache_wvalid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    dcache_rvalid <= 1'b0;
                    dcache_wvalid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: a behavioural memory, a hit/miss model and a response queue.
module tb_dcache_wt;
    localparam int NUM_LINES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dcache_addr = '0;
    logic        dcache_rreq = 1'b0;
    logic        dcache_wreq = 1'b0;
    logic [31:0] dcache_wdata = '0;
    logic [3:0]  dcache_byte_enable = '0;
    logic [31:0] dcache_rdata;
    logic        dcache_rvalid;
    logic        dcache_wvalid;
    logic [31:0] mem_addr;
    logic        mem_rreq;
    logic        mem_wreq;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        mem_wvalid = 1'b0;

    always #5 clk = ~clk;

    dcache_wt #(.NUM_LINES(NUM_LINES)) dut (
        .clk(clk), .rst_n(rst_n),
        .dcache_addr(dcache_addr), .dcache_rreq(dcache_rreq), .dcache_wreq(dcache_wreq),
        .dcache_wdata(dcache_wdata), .dcache_byte_enable(dcache_byte_enable),
        .dcache_rdata(dcache_rdata), .dcache_rvalid(dcache_rvalid), .dcache_wvalid(dcache_wvalid),
        .mem_addr(mem_addr), .mem_rreq(mem_rreq), .mem_wreq(mem_wreq), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_wvalid(mem_wvalid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing memory, word addressed; untouched words return an address-derived pattern.
    logic [31:0] mem [logic [29:0]];
    int rd_acks = 0;
    int wr_acks = 0;
    bit mem_mute = 1'b0;
    int wait_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return {wa[15:0], ~wa[15:0]};
    endfunction

    initial begin
        logic [31:0] w;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_wvalid = 1'b0;
            if ((mem_rreq || mem_wreq) && !mem_mute) begin
                if (wait_cnt == 2) begin
                    wait_cnt = 0;
                    if (mem_rreq) begin
                        mem_rdata  = mem_word(mem_addr[31:2]);
                        mem_rvalid = 1'b1;
                        rd_acks++;
                    end else begin
                        w = mem_word(mem_addr[31:2]);
                        for (int b = 0; b < 4; b++)
                            if (mem_byte_enable[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem[mem_addr[31:2]] = w;
                        mem_wvalid = 1'b1;
                        wr_acks++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Hit/miss model of the tag store.
    bit          mv [NUM_LINES];
    logic [29:0] mline [NUM_LINES];

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic clear_model();
        for (int i = 0; i < NUM_LINES; i++) mv[i] = 1'b0;
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input string tag);
        logic [29:0] wa;
        int          idx;
        bit          exp_miss;
        bit          seen;
        bit          addr_chk;
        int          cycles;
        int          r0;
        int          w0;
        exp_t        e;
        wa       = addr[31:2];
        idx      = int'(wa % NUM_LINES);
        exp_miss = !wr && (!mv[idx] || mline[idx] != wa);
        e.is_wr  = wr;
        e.data   = wr ? 32'h0 : mem_word(wa);
        sb.push_back(e);
        if (!wr) begin
            mv[idx]    = 1'b1;
            mline[idx] = wa;
        end
        r0 = rd_acks;
        w0 = wr_acks;
        @(negedge clk);
        dcache_addr        = addr;
        dcache_rreq        = rd;
        dcache_wreq        = wr;
        dcache_wdata       = wdata;
        dcache_byte_enable = be;
        seen     = 1'b0;
        addr_chk = 1'b0;
        cycles   = 0;
        while (cycles < 60 && !seen) begin
            @(posedge clk);
            #1;
            cycles++;
            if ((mem_rreq || mem_wreq) && !addr_chk) begin
                addr_chk = 1'b1;
                check({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                if (wr) begin
                    check({tag, "_mem_wdata"}, mem_wdata, wdata);
                    check({tag, "_mem_be"}, {28'h0, mem_byte_enable}, {28'h0, be});
                end
            end
            if (dcache_rvalid || dcache_wvalid) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_rvalid"}, {31'h0, dcache_rvalid}, {31'h0, !e.is_wr});
            check({tag, "_wvalid"}, {31'h0, dcache_wvalid}, {31'h0, e.is_wr});
            if (!e.is_wr) check({tag, "_rdata"}, dcache_rdata, e.data);
            if (!e.is_wr && !exp_miss) check({tag, "_hit_lat"}, cycles, 32'd1);
        end
        // Request stays up across the edge that leaves RESP; it must not be re-accepted.
        @(posedge clk);
        #1;
        check({tag, "_pulse_len"}, {31'h0, dcache_rvalid | dcache_wvalid}, 32'd0);
        dcache_rreq = 1'b0;
        dcache_wreq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_mem_rd_cnt"}, rd_acks - r0, {31'h0, exp_miss});
        check({tag, "_mem_wr_cnt"}, wr_acks - w0, {31'h0, wr});
    endtask

    initial begin
        logic [31:0] addrs [6];
        logic [31:0] a;
        int          cyc;
        addrs[0] = 32'h40; addrs[1] = 32'h80; addrs[2] = 32'hC0;
        addrs[3] = 32'h44; addrs[4] = 32'h10; addrs[5] = 32'h1040;
        clear_model();
        mem[30'h10] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", {31'h0, dcache_rvalid}, 32'd0);
        check("rst_wvalid", {31'h0, dcache_wvalid}, 32'd0);
        check("rst_mem_rreq", {31'h0, mem_rreq}, 32'd0);
        check("rst_mem_wreq", {31'h0, mem_wreq}, 32'd0);
        check("rst_rdata", dcache_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", {28'h0, mem_byte_enable}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1, 0, 32'h40, 0, 4'hF, "rd40_miss");
        check("rd40_value", dcache_rdata, 32'hDEAD_BEEF);
        do_req(1, 0, 32'h40, 0, 4'h0, "rd40_hit");
        do_req(0, 1, 32'h40, 32'h1122_3344, 4'b0011, "wr40_hit");
        do_req(1, 0, 32'h40, 0, 4'h0, "rd40_merged");
        check("rd40_merged_value", dcache_rdata, 32'hDEAD_3344);
        do_req(0, 1, 32'h80, 32'hCAFE_F00D, 4'hF, "wr80_miss");
        do_req(1, 0, 32'h80, 0, 4'hF, "rd80_noalloc");
        do_req(1, 0, 32'h40, 0, 4'hF, "rd40_evicted");
        do_req(1, 0, 32'h43, 0, 4'hF, "rd43_lowbits");
        do_req(1, 1, 32'h10, 32'hA5A5_5A5A, 4'b1100, "rdwr10");

        for (int i = 0; i < 24; i++) begin
            a = addrs[$urandom_range(0, 5)];
            if ($urandom_range(0, 2) == 0)
                do_req(0, 1, a, $urandom, 4'($urandom_range(0, 15)), "rand_wr");
            else
                do_req(1, 0, a, 0, 4'($urandom_range(0, 15)), "rand_rd");
        end

        // Reset while a refill is outstanding and memory never answers.
        mem_mute = 1'b1;
        @(negedge clk);
        dcache_addr = 32'h200;
        dcache_rreq = 1'b1;
        cyc = 0;
        while (!mem_rreq && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst_mid_rreq_seen", {31'h0, mem_rreq}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        dcache_rreq = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_mem_rreq", {31'h0, mem_rreq}, 32'd0);
        check("rst_mid_rvalid", {31'h0, dcache_rvalid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_mute = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_no_pulse", {31'h0, dcache_rvalid | dcache_wvalid}, 32'd0);
        do_req(1, 0, 32'h200, 0, 4'hF, "rd200_after_rst");
        do_req(1, 0, 32'h40, 0, 4'hF, "rd40_after_rst");
        do_req(1, 0, 32'h200, 0, 4'hF, "rd200_hit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of one-word direct-mapped lines (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports dcache_addr (32), dcache_rreq (1), dcache_wreq (1), dcache_wdata (32), dcache_byte_enable (4), all inputs from core.
REQ-005 SHALL have ports dcache_rdata (32), dcache_rvalid (1), dcache_wvalid (1), all outputs to core.
REQ-006 SHALL have ports mem_addr (32), mem_rreq (1), mem_wreq (1), mem_wdata (32), mem_byte_enable (4), all outputs to backing memory.
REQ-007 SHALL have ports mem_rdata (32), mem_rvalid (1), mem_wvalid (1), all inputs from backing memory.

Function
REQ-008 SHALL decode index = dcache_addr[2+IW-1:2] (IW = log2 NUM_LINES) and tag = dcache_addr[31:2+IW]; dcache_addr[1:0] ignored.
REQ-009 SHALL hold per line: valid bit, tag, 32-bit data word.
REQ-010 SHALL implement FSM states IDLE, READ_MISS, WRITE_MEM, RESP.
REQ-011 SHALL sample core requests only in IDLE; requests in READ_MISS, WRITE_MEM, RESP are ignored.
REQ-012 SHALL treat dcache_rreq and dcache_wreq both high as a write (write priority).
REQ-013 IDLE, rreq, hit (valid and tag match): next state RESP, dcache_rdata = line data registered.
REQ-014 IDLE, rreq, miss: next state READ_MISS; mem_rreq = 1, mem_addr = {dcache_addr[31:2],2'b00}.
REQ-015 READ_MISS: hold mem_rreq and mem_addr until mem_rvalid = 1; on that edge write line (valid=1, tag, mem_rdata), register dcache_rdata = mem_rdata, go RESP.
REQ-016 IDLE, wreq: next state WRITE_MEM; mem_wreq = 1, mem_addr word-aligned, mem_wdata = dcache_wdata, mem_byte_enable = dcache_byte_enable, all held until mem_wvalid = 1.
REQ-017 Write policy: write-through, no-write-allocate; on write hit, update only bytes with byte_enable bit set, on the edge leaving IDLE; write miss leaves the array unchanged.
REQ-018 WRITE_MEM: on edge with mem_wvalid = 1, go RESP.
REQ-019 RESP: exactly one cycle; dcache_rvalid = 1 if the request was a read, dcache_wvalid = 1 if a write; next state IDLE.
REQ-020 Latency: read hit, rvalid 1 cycle after request sampled; read miss, rvalid 1 cycle after mem_rvalid; write, wvalid 1 cycle after mem_wvalid.
REQ-021 dcache_rvalid, dcache_wvalid, mem_rreq, mem_wreq SHALL be registered outputs, 0 outside the states above.
REQ-022 dcache_rdata SHALL hold its last value until the next read response; dcache_byte_enable is ignored on reads (full word returned).
REQ-023 Core contract: request and operands stable from assertion until response pulse; request deasserted or replaced in the cycle after the pulse (guaranteed by RESP).
REQ-024 mem_rvalid/mem_wvalid outside READ_MISS/WRITE_MEM SHALL be ignored.
REQ-025 A write hitting a line whose refill is in progress is impossible (one outstanding request); no forwarding is required.

Reset
REQ-026 rst_n = 0 at a clock edge: state IDLE, all valid bits 0, dcache_rvalid/dcache_wvalid/mem_rreq/mem_wreq = 0, dcache_rdata = 0, mem_addr/mem_wdata/mem_byte_enable = 0.
REQ-027 Reset mid-READ_MISS or mid-WRITE_MEM: request dropped on the reset edge, no line written, no response pulse.
REQ-028 Tag and data arrays need not be reset; valid bits only.

Verification
REQ-029 After reset, rreq addr 0x0000_0040 -> mem_rreq addr 0x0000_0040; mem_rdata 0xDEAD_BEEF with mem_rvalid -> next cycle dcache_rvalid=1, rdata 0xDEAD_BEEF; repeat read -> rvalid 1 cycle after request, no mem_rreq.
REQ-030 Hit line 0x40 (0xDEAD_BEEF), wreq wdata 0x1122_3344 be 4'b0011 -> mem_wreq with be 0011, wvalid after ack; re-read returns 0xDEAD_3344 without memory access.
REQ-031 Write miss to 0x80 then read 0x80 -> read issues mem_rreq (no allocate on write).
REQ-032 Conflict: read 0x40 then 0x40+4*NUM_LINES (0x80 for 16) -> both miss; re-read 0x40 misses again (evicted).
REQ-033 rst_n low while mem_rreq high, mem_rvalid never returned -> mem_rreq 0 next cycle, no rvalid; subsequent read to same address misses.
REQ-034 rreq and wreq together at 0x10 -> only mem_wreq issued, response is dcache_wvalid only; held request during RESP not re-accepted (exactly one mem transaction).
